// File: rtl/token_precision_encoder.sv
// ---------------------------------------------------------------------------
// token_precision_encoder
//
// Producer side of the mixed-precision attention datapath. Collects one Q1.15
// attention column and tracks its peak magnitude. It then picks a per-column
// precision code (INT4 / INT8 / FP16) and emits the column quantized into the
// low bits of 16-bit words.
//
// Build option:
//   TPE_ROUND_EN - when defined, INT8/INT4 use round-half-up (addend 128/2048);
//                  when undefined, plain truncation (addend 0). Saturation,
//                  the FP16 path and the precision decision are identical.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start           - begin a matrix (only honoured in IDLE)
//   in_valid/ready  - input element handshake; in_ready high only in COLLECT
//   in_data         - signed Q1.15 element, row order within a column
//   out_valid/ready - quantized element handshake (registered outputs)
//   out_data        - quantized element, sign-extended to 16 bits
//   out_row/out_col - position of out_data in the matrix
//   precision_sel   - per-column code: 00 INT4, 01 INT8, 10 FP16
//   busy            - high whenever the FSM is not IDLE
//   done            - one-cycle pulse once the last column has been emitted
// ---------------------------------------------------------------------------
module token_precision_encoder #(
    parameter int          A_ROWS   = 8,
    parameter int          NUM_COLS = 8,
    parameter logic [15:0] THR_HI   = 16'h2000,
    parameter logic [15:0] THR_LO   = 16'h0800
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [15:0]            in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [15:0]            out_data,
    output logic [$clog2(A_ROWS)-1:0]     out_row,
    output logic [$clog2(NUM_COLS)-1:0]   out_col,
    output logic [NUM_COLS-1:0][1:0]      precision_sel,
    output logic                          busy,
    output logic                          done
);

    localparam int RW = $clog2(A_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(A_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    localparam logic [1:0] SEL_INT4 = 2'b00;
    localparam logic [1:0] SEL_INT8 = 2'b01;
    localparam logic [1:0] SEL_FP16 = 2'b10;

`ifdef TPE_ROUND_EN
    localparam logic signed [16:0] ADD_INT8 = 17'sd128;
    localparam logic signed [16:0] ADD_INT4 = 17'sd2048;
`else
    localparam logic signed [16:0] ADD_INT8 = 17'sd0;
    localparam logic signed [16:0] ADD_INT4 = 17'sd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [RW-1:0]             row_q;
    logic [CW-1:0]             col_q;
    logic [15:0]               peak_q;
    logic                      out_valid_q;
    logic signed [15:0]        out_data_q;
    logic [RW-1:0]             out_row_q;
    logic [CW-1:0]             out_col_q;
    logic [NUM_COLS-1:0][1:0]  sel_q;
    logic signed [15:0]        buf_q [A_ROWS];

    logic          in_hs;
    logic          out_hs;
    logic [15:0]   abs_in;
    logic [1:0]    sel_now;
    logic [RW-1:0] next_row;

    // |x| with -32768 saturating to 32767 so the peak always fits in 15 bits.
    function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
        if (x == 16'sh8000)
            return 16'h7FFF;
        else if (x < 0)
            return 16'(-x);
        else
            return x;
    endfunction

    // Sign-extend to 17 bits before adding so +addend can never wrap.
    function automatic logic signed [16:0] round_add(input logic signed [15:0] x,
                                                     input logic signed [16:0] addend);
        return {x[15], x} + addend;
    endfunction

    // Clamp to [-lim-1, lim]; result is already sign-extended to 16 bits.
    function automatic logic signed [15:0] sat_q(input logic signed [16:0] v,
                                                 input logic signed [16:0] lim);
        if (v > lim)
            return lim[15:0];
        else if (v < (-lim - 17'sd1))
            return 16'(-lim - 17'sd1);
        else
            return v[15:0];
    endfunction

    function automatic logic signed [15:0] quantize(input logic signed [15:0] x,
                                                    input logic [1:0] sel);
        case (sel)
            SEL_INT8: return sat_q(round_add(x, ADD_INT8) >>> 8, 17'sd127);
            SEL_INT4: return sat_q(round_add(x, ADD_INT4) >>> 12, 17'sd7);
            default:  return x;
        endcase
    endfunction

    function automatic logic [1:0] decide(input logic [15:0] peak);
        if (peak >= THR_HI)
            return SEL_FP16;
        else if (peak >= THR_LO)
            return SEL_INT8;
        else
            return SEL_INT4;
    endfunction

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign abs_in   = abs_sat(in_data);
    assign sel_now  = decide(peak_q);
    assign next_row = out_row_q + 1'b1;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: if (in_hs && (row_q == LAST_ROW)) state_d = S_DECIDE;
            S_DECIDE:  state_d = S_EMIT;
            S_EMIT: begin
                if (out_hs && (out_row_q == LAST_ROW))
                    state_d = (col_q == LAST_COL) ? S_DONE : S_COLLECT;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---- FSM: outputs decoded from state ----
    always_comb begin
        in_ready = (state_q == S_COLLECT);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    // ---- Collect: column buffer (data only, not reset) ----
    always_ff @(posedge clk) begin
        if (in_hs)
            buf_q[row_q] <= in_data;
    end

    // ---- Control, peak tracking, decision and registered output stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            peak_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            sel_q       <= {NUM_COLS{SEL_FP16}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q  <= '0;
                        col_q  <= '0;
                        peak_q <= '0;
                    end
                end
                S_COLLECT: begin
                    if (in_hs) begin
                        row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                        if (abs_in > peak_q)
                            peak_q <= abs_in;
                    end
                end
                S_DECIDE: begin
                    // Code is committed here so it is visible before row 0 leaves.
                    sel_q[col_q] <= sel_now;
                    out_valid_q  <= 1'b1;
                    out_data_q   <= quantize(buf_q[0], sel_now);
                    out_row_q    <= '0;
                    out_col_q    <= col_q;
                end
                S_EMIT: begin
                    if (out_hs) begin
                        if (out_row_q == LAST_ROW) begin
                            out_valid_q <= 1'b0;
                            row_q       <= '0;
                            peak_q      <= '0;
                            if (col_q != LAST_COL)
                                col_q <= col_q + 1'b1;
                        end else begin
                            out_row_q  <= next_row;
                            out_data_q <= quantize(buf_q[next_row], sel_q[col_q]);
                        end
                    end
                end
                S_DONE: begin
                    col_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_row       = out_row_q;
    assign out_col       = out_col_q;
    assign precision_sel = sel_q;

endmodule

// File: tb/tb_token_precision_encoder.sv
module tb_token_precision_encoder;

    localparam int A_ROWS   = 8;
    localparam int NUM_COLS = 8;
`ifdef TPE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start, in_valid, out_ready;
    logic [15:0] in_data;

    logic a_in_ready, a_out_valid, a_busy, a_done;
    logic [15:0] a_out_data;
    logic [2:0]  a_out_row, a_out_col;
    logic [NUM_COLS-1:0][1:0] a_sel;

    logic b_in_ready, b_out_valid, b_busy, b_done;
    logic [15:0] b_out_data;
    logic [2:0]  b_out_row, b_out_col;
    logic [NUM_COLS-1:0][1:0] b_sel;

    token_precision_encoder #(.A_ROWS(A_ROWS), .NUM_COLS(NUM_COLS)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_row(a_out_row),
        .out_col(a_out_col), .precision_sel(a_sel), .busy(a_busy), .done(a_done));

    // Second instance: THR_LO = 0 and THR_HI above any peak, so every column is INT8.
    token_precision_encoder #(.A_ROWS(A_ROWS), .NUM_COLS(NUM_COLS),
                              .THR_HI(16'hFFFF), .THR_LO(16'h0000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_row(b_out_row),
        .out_col(b_out_col), .precision_sel(b_sel), .busy(b_busy), .done(b_done));

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [A_ROWS-1:0][15:0] d;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        int          spot_row;
        logic [15:0] spot_a;
        logic [15:0] spot_b;
    } vec_t;

    typedef struct {
        logic [15:0] da;
        logic [15:0] db;
        int          row;
        int          col;
    } exp_t;

    vec_t tbl [NUM_COLS];
    exp_t sbq [$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_col(input int c,
                           input logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7,
                           input logic [1:0] sa, sb, input int sr,
                           input logic [15:0] xa, xb);
        tbl[c].d[0] = r0; tbl[c].d[1] = r1; tbl[c].d[2] = r2; tbl[c].d[3] = r3;
        tbl[c].d[4] = r4; tbl[c].d[5] = r5; tbl[c].d[6] = r6; tbl[c].d[7] = r7;
        tbl[c].sel_a = sa; tbl[c].sel_b = sb; tbl[c].spot_row = sr;
        tbl[c].spot_a = xa; tbl[c].spot_b = xb;
    endtask

    // Reference model: precision decision from the column peak.
    function automatic logic [1:0] m_sel(input logic [A_ROWS-1:0][15:0] d,
                                         input int hi, input int lo);
        int pk = 0;
        for (int r = 0; r < A_ROWS; r++) begin
            int v = int'($signed(d[r]));
            int a = (v < 0) ? -v : v;
            if (a > 32767) a = 32767;
            if (a > pk) pk = a;
        end
        if (pk >= hi) return 2'b10;
        if (pk >= lo) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: quantization via floor division and clamping.
    function automatic logic [15:0] m_q(input logic [15:0] x, input logic [1:0] sel);
        int v, dv, lim, q;
        if (sel == 2'b10) return x;
        dv  = (sel == 2'b01) ? 256 : 4096;
        lim = (sel == 2'b01) ? 127 : 7;
        v   = int'($signed(x)) + (RND ? dv / 2 : 0);
        q   = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
        if (q > lim) q = lim;
        if (q < -lim - 1) q = -lim - 1;
        return 16'(q);
    endfunction

    task automatic drive_cols(input int ncols);
        exp_t e;
        for (int c = 0; c < ncols; c++) begin
            for (int r = 0; r < A_ROWS; r++) begin
                int t = 0;
                in_valid = 1'b1;
                in_data  = tbl[c].d[r];
                while (!a_in_ready && t < 300) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 300) begin
                    n_total++;
                    $display("FAIL drv_timeout col %0d row %0d: in_ready never rose", c, r);
                    in_valid = 1'b0;
                    return;
                end
                if (r == A_ROWS - 1) begin
                    for (int k = 0; k < A_ROWS; k++) begin
                        e.row = k;
                        e.col = c;
                        e.da  = m_q(tbl[c].d[k], m_sel(tbl[c].d, 8192, 2048));
                        e.db  = m_q(tbl[c].d[k], m_sel(tbl[c].d, 65535, 0));
                        sbq.push_back(e);
                    end
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic monitor(input int npops, input int stall_col);
        int popped = 0;
        int cyc = 0;
        int stall = 0;
        exp_t e;
        while (popped < npops) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                chk("mon_timeout_pops", popped, npops);
                return;
            end
            if (a_out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", a_out_valid, 1'b0);
                    out_ready = 1'b1;
                end else if (sbq[0].col == stall_col && sbq[0].row == 3 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                    chk($sformatf("stall%0d_data", stall), a_out_data, sbq[0].da);
                    chk($sformatf("stall%0d_row", stall), a_out_row, sbq[0].row);
                end else if (cyc % 5 == 2) begin
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    e = sbq.pop_front();
                    popped++;
                    chk($sformatf("a_data c%0d r%0d", e.col, e.row), a_out_data, e.da);
                    chk($sformatf("a_row c%0d r%0d", e.col, e.row), a_out_row, e.row);
                    chk($sformatf("a_col c%0d r%0d", e.col, e.row), a_out_col, e.col);
                    chk($sformatf("b_valid c%0d r%0d", e.col, e.row), b_out_valid, 1'b1);
                    chk($sformatf("b_data c%0d r%0d", e.col, e.row), b_out_data, e.db);
                    if (e.row == 0) begin
                        chk($sformatf("a_sel c%0d", e.col), a_sel[e.col], tbl[e.col].sel_a);
                        chk($sformatf("b_sel c%0d", e.col), b_sel[e.col], tbl[e.col].sel_b);
                    end
                    if (e.row == tbl[e.col].spot_row) begin
                        chk($sformatf("a_spot c%0d", e.col), a_out_data, tbl[e.col].spot_a);
                        chk($sformatf("b_spot c%0d", e.col), b_out_data, tbl[e.col].spot_b);
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic do_start();
        chk("in_ready_idle", a_in_ready, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", a_in_ready, 1'b1);
        chk("busy_after_start", a_busy, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_out_valid"}, a_out_valid, 1'b0);
        chk({tag, "_a_out_data"}, a_out_data, 16'h0000);
        chk({tag, "_a_out_row"}, a_out_row, 3'd0);
        chk({tag, "_a_out_col"}, a_out_col, 3'd0);
        chk({tag, "_a_in_ready"}, a_in_ready, 1'b0);
        chk({tag, "_a_busy"}, a_busy, 1'b0);
        chk({tag, "_a_done"}, a_done, 1'b0);
        chk({tag, "_a_sel"}, a_sel, {NUM_COLS{2'b10}});
        chk({tag, "_b_sel"}, b_sel, {NUM_COLS{2'b10}});
        chk({tag, "_b_in_ready"}, b_in_ready, 1'b0);
        chk({tag, "_b_busy"}, b_busy, 1'b0);
    endtask

    initial begin
        logic [NUM_COLS-1:0][1:0] sel_all;

        //       col  r0       r1       r2       r3       r4       r5       r6       r7       selA   selB   spot  spotA                      spotB
        set_col(0, 16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000, 2'b10, 2'b01, 3, 16'h4000, 16'h0040);
        set_col(1, 16'h1000,16'h1000,16'h1000,16'h1000,16'h1000,16'h1000,16'h1000,16'h1000, 2'b01, 2'b01, 0, 16'h0010, 16'h0010);
        set_col(2, 16'h0700,16'hFF00,16'h0123,16'hF900,16'h0000,16'h0010,16'hFFF0,16'h0400, 2'b00, 2'b01, 1, RND ? 16'h0000 : 16'hFFFF, 16'hFFFF);
        set_col(3, 16'h0100,16'hFF00,16'h8000,16'h0200,16'h0FFF,16'hF000,16'h0001,16'hFFFF, 2'b10, 2'b01, 2, 16'h8000, 16'hFF80);
        set_col(4, 16'h07FF,16'h0000,16'hF801,16'h0100,16'h0080,16'hFF80,16'h0007,16'hFFF9, 2'b00, 2'b01, 0, 16'h0000, RND ? 16'h0008 : 16'h0007);
        set_col(5, 16'h0000,16'h1234,16'hEDCC,16'h0800,16'hF800,16'h7FFF,16'h0001,16'h8001, 2'b10, 2'b01, 5, 16'h7FFF, 16'h007F);
        set_col(6, 16'h0800,16'h0400,16'h0001,16'h07FF,16'hF800,16'h0000,16'hFC00,16'h0081, 2'b01, 2'b01, 4, 16'hFFF8, 16'hFFF8);
        set_col(7, 16'h1FFF,16'h0000,16'h0080,16'hFF7F,16'h1000,16'hF000,16'h0C00,16'hE000, 2'b10, 2'b01, 7, 16'hE000, 16'hFFE0);

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Full matrix with a 5-cycle out_ready stall in column 1.
        do_start();
        fork
            drive_cols(NUM_COLS);
            monitor(NUM_COLS * A_ROWS, 1);
        join
        @(negedge clk);
        chk("done_pulse_a", a_done, 1'b1);
        chk("done_pulse_b", b_done, 1'b1);
        chk("busy_in_done", a_busy, 1'b1);
        chk("out_valid_after_last", a_out_valid, 1'b0);
        chk("in_ready_in_done", a_in_ready, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", a_done, 1'b0);
        chk("busy_fall", a_busy, 1'b0);
        for (int c = 0; c < NUM_COLS; c++) sel_all[c] = tbl[c].sel_a;
        chk("sel_persist_a", a_sel, sel_all);

        // Asynchronous reset while column 3 is being emitted.
        do_start();
        fork
            drive_cols(4);
            monitor(3 * A_ROWS + 3, -1);
        join
        @(negedge clk);
        chk("pre_rst_out_valid", a_out_valid, 1'b1);
        chk("pre_rst_out_col", a_out_col, 3'd3);
        chk("pre_rst_out_row", a_out_row, 3'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart must begin again at column 0.
        do_start();
        fork
            drive_cols(1);
            monitor(A_ROWS, -1);
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
